hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised hazard unit for the 5-stage pipelined RISC-V core; it generalises the fixed single-bubble hazard unit.
- Takes register indices and control bits from the D/E/M/W stages.
- Produces stall, flush and forwarding selects.
- Adds a load-use stall FSM sized for a configurable data-memory latency, operand-use qualification and branch-flush priority over stalls.

Parameters:
REG_AW, 5, register address width (x0 is always index 0)
LOAD_LAT, 1, bubbles required between a load in E and a dependent instruction (1..7)
CNT_W, 3, stall counter width; must satisfy 2^CNT_W > LOAD_LAT

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
rs1_d  in  REG_AW  decode source 1
rs2_d  in  REG_AW  decode source 2
rs1_used_d  in  1  instruction in D reads rs1
rs2_used_d  in  1  instruction in D reads rs2
rs1_e  in  REG_AW  execute source 1
rs2_e  in  REG_AW  execute source 2
rd_e  in  REG_AW  execute destination
result_src_e  in  2  2'b01 = load in E
reg_write_e  in  1  E writes the register file
pc_src_e  in  1  branch/jump taken in E
rd_m  in  REG_AW  memory-stage destination
reg_write_m  in  1  M writes the register file
rd_w  in  REG_AW  writeback destination
reg_write_w  in  1  W writes the register file
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID register
flush_d  out  1  clear IF/ID register
flush_e  out  1  clear ID/EX register (bubble)
forward_a_e  out  2  ALU A select: 00 register file, 10 M result, 01 W result
forward_b_e  out  2  ALU B select, same encoding

Behaviour:
- Forwarding is combinational.
  - forward_a_e = 10 if reg_write_m && rd_m==rs1_e && rs1_e!=0.
  - Else 01 if reg_write_w && rd_w==rs1_e && rs1_e!=0.
  - Else 00.
  - M has priority over W. forward_b_e is the same rule using rs2_e.
- Load-use detect, combinational:
  - lu = result_src_e==01 && reg_write_e && rd_e!=0 && ((rs1_used_d && rs1_d==rd_e) || (rs2_used_d && rs2_d==rd_e)).
- FSM states are IDLE and HOLD, with stall counter cnt (CNT_W bits).
- IDLE:
  - If lu && !pc_src_e: assert stall_f, stall_d, flush_e this cycle.
  - If LOAD_LAT>1 in that case: go to HOLD with cnt=LOAD_LAT-1.
  - Otherwise stay in IDLE.
- HOLD:
  - Assert stall_f, stall_d, flush_e each cycle.
  - cnt decrements each cycle; leave for IDLE in the cycle cnt reaches 1 (after its stall).
  - Total bubbles equal LOAD_LAT exactly.
- Branch priority: pc_src_e in any state has these effects:
  - flush_d=1, flush_e=1, stall_f=0, stall_d=0.
  - FSM is forced to IDLE and cnt is cleared.
  - A pending load-use stall is abandoned, because the dependent instruction is squashed.
- flush_e is the OR of the stall bubble and the branch flush.
- x0 never causes a stall or a forward.
- Unused operands (rs*_used_d=0) never stall.
- Reset: state=IDLE, cnt=0.
  - All outputs 0 while rst is high, including the combinational forward selects, which are gated by rst.
  - Reset mid-HOLD aborts the stall on the next edge.
- Simultaneous M and W match on the same register: M wins.
- A load in E whose rd matches only rs*_e (not D) does not stall.

Optional Feature:
- Macro HZ_PERF_EN.
- When defined, adds outputs stall_cnt_o [31:0] and flush_cnt_o [31:0].
  - stall_cnt_o increments on every cycle with stall_d=1.
  - flush_cnt_o increments on every cycle with pc_src_e=1.
  - Both are saturating at 32'hFFFFFFFF and cleared by rst.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - Forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - RESULT_LOAD=2'b01.
  - FSM state typedef (IDLE, HOLD).
- One sub-module, hz_forward_sel: a combinational single-operand forward mux select, instantiated twice (A and B).

Test Plan:
- Forwarding:
  - rd_m=5, reg_write_m=1, rs1_e=5 -> forward_a_e=10.
  - Add rd_w=5, reg_write_w=1 -> still 10.
  - Set rd_m=0 -> 01.
  - rs1_e=0 with all matches -> 00.
- Load-use, LOAD_LAT=1: load rd_e=7 with rs2_d=7, rs2_used_d=1 -> exactly 1 cycle of stall_f=stall_d=flush_e=1, then all 0.
- LOAD_LAT=3, same stimulus held -> 3 consecutive stall cycles, then IDLE.
  - Same case with rs2_used_d=0 -> no stall.
- Branch during HOLD (LOAD_LAT=3):
  - pc_src_e=1 in the 2nd stall cycle -> that cycle flush_d=flush_e=1, stall_f=stall_d=0.
  - Next cycle all outputs 0, state IDLE.
- Reset mid-HOLD: assert rst in the 2nd stall cycle -> next edge outputs all 0, no residual stall after rst drops.
- HZ_PERF_EN:
  - 4 load-use stalls (LOAD_LAT=2) and 3 taken branches -> stall_cnt_o=8, flush_cnt_o=3.
  - Preload near saturation via a long stall run -> stall_cnt_o holds at max.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline encodings for the RISC-V core hazard logic: forward selects,
// result-source codes and the load-use stall FSM state type.
package riscv_pipe_pkg;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hz_forward_sel.sv
// Single-operand bypass select: the M stage beats the W stage, and x0 is never bypassed.
module hz_forward_sel
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    output logic [1:0]        fwd_sel_c
);

    always_comb begin
        fwd_sel_c = FWD_RF;
        if (reg_write_m && (rd_m == rs_e) && (rs_e != '0)) begin
            fwd_sel_c = FWD_M;
        end else if (reg_write_w && (rd_w == rs_e) && (rs_e != '0)) begin
            fwd_sel_c = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage core: operand forwarding, multi-bubble load-use stall, branch flush.
// Optional HZ_PERF_EN adds saturating stall/flush event counters.
module hazard_scoreboard
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              rs1_used_d,
    input  logic              rs2_used_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [1:0]        result_src_e,
    input  logic              reg_write_e,
    input  logic              pc_src_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e
`ifdef HZ_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

    hz_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             lu_c;
    logic             stall_c;
    logic             flush_br_c;
    logic [1:0]       fwd_a_c;
    logic [1:0]       fwd_b_c;

    hz_forward_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_e        (rs1_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .fwd_sel_c   (fwd_a_c)
    );

    hz_forward_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_e        (rs2_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .fwd_sel_c   (fwd_b_c)
    );

    // Only operands the decoded instruction actually reads can create a load-use hazard.
    assign lu_c = (result_src_e == RESULT_LOAD) && reg_write_e && (rd_e != '0) &&
                  ((rs1_used_d && (rs1_d == rd_e)) || (rs2_used_d && (rs2_d == rd_e)));

    // A taken branch squashes the dependent instruction, so it overrides any stall.
    assign flush_br_c = !rst && pc_src_e;
    assign stall_c    = !rst && !pc_src_e && ((state == HOLD) || lu_c);

    // First bubble is raised from IDLE; HOLD supplies the remaining LOAD_LAT-1.
    always_ff @(posedge clk) begin
        if (rst || pc_src_e) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lu_c && (LOAD_LAT > 1)) begin
                        state <= HOLD;
                        cnt   <= CNT_W'(LOAD_LAT - 1);
                    end
                end
                HOLD: begin
                    if (cnt <= CNT_W'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign stall_f     = stall_c;
    assign stall_d     = stall_c;
    assign flush_d     = flush_br_c;
    assign flush_e     = stall_c || flush_br_c;
    assign forward_a_e = rst ? FWD_RF : fwd_a_c;
    assign forward_b_e = rst ? FWD_RF : fwd_b_c;

`ifdef HZ_PERF_EN
    // Saturating event counters for stall cycles and taken-branch cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_c && (stall_cnt_o != PERF_MAX)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (pc_src_e && (flush_cnt_o != PERF_MAX)) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus.
// Directed vector table, hand-written stall/branch/reset sequences, then random checks against a model.
module tb_hazard_scoreboard;

    typedef struct packed {
        logic [4:0] rs1_d;
        logic [4:0] rs2_d;
        logic       rs1_used_d;
        logic       rs2_used_d;
        logic [4:0] rs1_e;
        logic [4:0] rs2_e;
        logic [4:0] rd_e;
        logic [1:0] result_src_e;
        logic       reg_write_e;
        logic       pc_src_e;
        logic [4:0] rd_m;
        logic       reg_write_m;
        logic [4:0] rd_w;
        logic       reg_write_w;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [7:0] exp;
        string      name;
    } vec_t;

    // Output packing: {stall_f, stall_d, flush_d, flush_e, forward_a_e, forward_b_e}
    localparam logic [7:0] O_ZERO  = 8'b0000_00_00;
    localparam logic [7:0] O_STALL = 8'b1101_00_00;
    localparam logic [7:0] O_BR    = 8'b0011_00_00;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    stim_t st  = '0;

    logic       stall_f1, stall_d1, flush_d1, flush_e1;
    logic [1:0] fa1, fb1;
    logic       stall_f3, stall_d3, flush_d3, flush_e3;
    logic [1:0] fa3, fb3;
    logic [7:0] out1, out3;

    int n_checks = 0;
    int n_fail   = 0;
    int bub1     = 0;
    int bub3     = 0;

`ifdef HZ_PERF_EN
    logic [31:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;
    logic [31:0] m_sc1 = '0;
    logic [31:0] m_fc1 = '0;
    logic [31:0] m_sc3 = '0;
    logic [31:0] m_fc3 = '0;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .rs1_d(st.rs1_d), .rs2_d(st.rs2_d),
        .rs1_used_d(st.rs1_used_d), .rs2_used_d(st.rs2_used_d),
        .rs1_e(st.rs1_e), .rs2_e(st.rs2_e), .rd_e(st.rd_e),
        .result_src_e(st.result_src_e), .reg_write_e(st.reg_write_e), .pc_src_e(st.pc_src_e),
        .rd_m(st.rd_m), .reg_write_m(st.reg_write_m),
        .rd_w(st.rd_w), .reg_write_w(st.reg_write_w),
        .stall_f(stall_f1), .stall_d(stall_d1), .flush_d(flush_d1), .flush_e(flush_e1),
        .forward_a_e(fa1), .forward_b_e(fb1)
`ifdef HZ_PERF_EN
        , .stall_cnt_o(stall_cnt1), .flush_cnt_o(flush_cnt1)
`endif
    );

    hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .rs1_d(st.rs1_d), .rs2_d(st.rs2_d),
        .rs1_used_d(st.rs1_used_d), .rs2_used_d(st.rs2_used_d),
        .rs1_e(st.rs1_e), .rs2_e(st.rs2_e), .rd_e(st.rd_e),
        .result_src_e(st.result_src_e), .reg_write_e(st.reg_write_e), .pc_src_e(st.pc_src_e),
        .rd_m(st.rd_m), .reg_write_m(st.reg_write_m),
        .rd_w(st.rd_w), .reg_write_w(st.reg_write_w),
        .stall_f(stall_f3), .stall_d(stall_d3), .flush_d(flush_d3), .flush_e(flush_e3),
        .forward_a_e(fa3), .forward_b_e(fb3)
`ifdef HZ_PERF_EN
        , .stall_cnt_o(stall_cnt3), .flush_cnt_o(flush_cnt3)
`endif
    );

    assign out1 = {stall_f1, stall_d1, flush_d1, flush_e1, fa1, fb1};
    assign out3 = {stall_f3, stall_d3, flush_d3, flush_e3, fa3, fb3};

    function automatic stim_t fs(input int rs1_d, input int rs2_d, input int u1, input int u2,
                                 input int rs1_e, input int rs2_e, input int rd_e,
                                 input int src, input int we, input int pc,
                                 input int rd_m, input int wm, input int rd_w, input int ww);
        stim_t s;
        s.rs1_d        = 5'(rs1_d);
        s.rs2_d        = 5'(rs2_d);
        s.rs1_used_d   = 1'(u1);
        s.rs2_used_d   = 1'(u2);
        s.rs1_e        = 5'(rs1_e);
        s.rs2_e        = 5'(rs2_e);
        s.rd_e         = 5'(rd_e);
        s.result_src_e = 2'(src);
        s.reg_write_e  = 1'(we);
        s.pc_src_e     = 1'(pc);
        s.rd_m         = 5'(rd_m);
        s.reg_write_m  = 1'(wm);
        s.rd_w         = 5'(rd_w);
        s.reg_write_w  = 1'(ww);
        return s;
    endfunction

    // Reference model: bypass priority, load-use condition and a count of bubbles still owed.
    function automatic logic [1:0] m_fwd(input logic [4:0] rs, input stim_t s);
        if (rs == 5'd0) return 2'b00;
        if (s.reg_write_m && s.rd_m == rs) return 2'b10;
        if (s.reg_write_w && s.rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_lu(input stim_t s);
        return (s.result_src_e == 2'b01) && s.reg_write_e && (s.rd_e != 5'd0) &&
               ((s.rs1_used_d && s.rs1_d == s.rd_e) || (s.rs2_used_d && s.rs2_d == s.rd_e));
    endfunction

    function automatic logic [7:0] m_out(input stim_t s, input logic r, input int owed);
        logic stall;
        if (r) return 8'h00;
        stall = !s.pc_src_e && (owed > 0 || m_lu(s));
        return {stall, stall, s.pc_src_e, stall | s.pc_src_e, m_fwd(s.rs1_e, s), m_fwd(s.rs2_e, s)};
    endfunction

    function automatic int m_owed_next(input stim_t s, input logic r, input int owed, input int lat);
        if (r || s.pc_src_e) return 0;
        if (owed > 0) return owed - 1;
        if (m_lu(s)) return lat - 1;
        return 0;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

`ifdef HZ_PERF_EN
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask
`endif

    // One cycle: drive after the falling edge, compare both instances to the model, advance the model.
    task automatic step(input stim_t s, input logic r, output logic [7:0] a1, output logic [7:0] a3);
        logic [7:0] e1, e3;
        @(negedge clk);
        st  = s;
        rst = r;
        #1;
        a1 = out1;
        a3 = out3;
        e1 = m_out(s, r, bub1);
        e3 = m_out(s, r, bub3);
        check("model_lat1", a1, e1);
        check("model_lat3", a3, e3);
`ifdef HZ_PERF_EN
        check32("stall_cnt_lat1", stall_cnt1, m_sc1);
        check32("flush_cnt_lat1", flush_cnt1, m_fc1);
        check32("stall_cnt_lat3", stall_cnt3, m_sc3);
        check32("flush_cnt_lat3", flush_cnt3, m_fc3);
        if (r) begin
            m_sc1 = '0; m_fc1 = '0; m_sc3 = '0; m_fc3 = '0;
        end else begin
            if (e1[7] && m_sc1 != 32'hFFFF_FFFF) m_sc1 = m_sc1 + 32'd1;
            if (e3[7] && m_sc3 != 32'hFFFF_FFFF) m_sc3 = m_sc3 + 32'd1;
            if (s.pc_src_e && m_fc1 != 32'hFFFF_FFFF) m_fc1 = m_fc1 + 32'd1;
            if (s.pc_src_e && m_fc3 != 32'hFFFF_FFFF) m_fc3 = m_fc3 + 32'd1;
        end
`endif
        bub1 = m_owed_next(s, r, bub1, 1);
        bub3 = m_owed_next(s, r, bub3, 3);
    endtask

    initial begin
        vec_t       vecs[13];
        stim_t      z, ld, s;
        logic [7:0] a1, a3;
        logic       r;

        z  = '0;
        ld = fs(0, 7, 0, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0);

        //           rs1d rs2d u1 u2 rs1e rs2e rde src we pc rdm wm rdw ww
        vecs[0]  = '{fs(0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 5, 1, 0, 0), 8'b0000_10_00, "fwd_a_m"};
        vecs[1]  = '{fs(0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 5, 1, 5, 1), 8'b0000_10_00, "fwd_a_m_over_w"};
        vecs[2]  = '{fs(0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 5, 1), 8'b0000_01_00, "fwd_a_w"};
        vecs[3]  = '{fs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), 8'b0000_00_00, "fwd_x0"};
        vecs[4]  = '{fs(0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 9, 0, 9, 1), 8'b0000_00_01, "fwd_b_w_m_off"};
        vecs[5]  = '{fs(0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 3, 1, 4, 1), 8'b0000_10_10, "fwd_ab_m"};
        vecs[6]  = '{fs(2, 0, 1, 0, 7, 0, 7, 1, 1, 0, 0, 0, 0, 0), 8'b0000_00_00, "load_match_e_only"};
        vecs[7]  = '{fs(0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 8'b0000_00_00, "load_rd_x0"};
        vecs[8]  = '{fs(7, 7, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0), 8'b0000_00_00, "load_operands_unused"};
        vecs[9]  = '{fs(0, 7, 0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0), 8'b0000_00_00, "load_no_regwrite"};
        vecs[10] = '{fs(0, 7, 0, 1, 0, 0, 7, 2, 1, 0, 0, 0, 0, 0), 8'b0000_00_00, "non_load_src"};
        vecs[11] = '{fs(0, 7, 0, 1, 0, 0, 7, 1, 1, 1, 0, 0, 0, 0), 8'b0011_00_00, "branch_over_lu"};
        vecs[12] = '{fs(0, 0, 0, 0, 0, 6, 0, 0, 0, 1, 6, 1, 0, 0), 8'b0011_00_10, "branch_with_fwd"};

        // Reset: everything gated, even with hazards and matches present.
        step(fs(0, 7, 0, 1, 5, 0, 7, 1, 1, 0, 5, 1, 0, 0), 1'b1, a1, a3);
        check("reset_lat1", a1, O_ZERO);
        check("reset_lat3", a3, O_ZERO);
        step(fs(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b1, a1, a3);
        check("reset_branch_gated", a3, O_ZERO);

        foreach (vecs[i]) begin
            step(vecs[i].s, 1'b0, a1, a3);
            check({vecs[i].name, "_lat1"}, a1, vecs[i].exp);
            check({vecs[i].name, "_lat3"}, a3, vecs[i].exp);
        end

        // Load-use with the bubble entering E afterwards: LOAD_LAT=1 stalls once, LOAD_LAT=3 three times.
        step(ld, 1'b0, a1, a3);
        check("lu_lat1_stall", a1, O_STALL);
        check("lu_lat3_stall1", a3, O_STALL);
        step(z, 1'b0, a1, a3);
        check("lu_lat1_release", a1, O_ZERO);
        check("lu_lat3_stall2", a3, O_STALL);
        step(z, 1'b0, a1, a3);
        check("lu_lat3_stall3", a3, O_STALL);
        step(z, 1'b0, a1, a3);
        check("lu_lat3_release", a3, O_ZERO);

        // Same stimulus held for three cycles on LOAD_LAT=3.
        for (int i = 0; i < 3; i++) begin
            step(ld, 1'b0, a1, a3);
            check("lu_held_lat3", a3, O_STALL);
        end
        step(z, 1'b0, a1, a3);
        check("lu_held_lat3_idle", a3, O_ZERO);

        // Unused rs2 never stalls.
        s = ld;
        s.rs2_used_d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(s, 1'b0, a1, a3);
            check("lu_unused_lat3", a3, O_ZERO);
            check("lu_unused_lat1", a1, O_ZERO);
        end

        // Taken branch in the second stall cycle abandons the stall.
        step(ld, 1'b0, a1, a3);
        check("br_hold_stall1", a3, O_STALL);
        s = ld;
        s.pc_src_e = 1'b1;
        step(s, 1'b0, a1, a3);
        check("br_hold_flush", a3, O_BR);
        step(z, 1'b0, a1, a3);
        check("br_hold_after1", a3, O_ZERO);
        step(z, 1'b0, a1, a3);
        check("br_hold_after2", a3, O_ZERO);

        // Reset in the second stall cycle aborts the stall with nothing left over.
        step(ld, 1'b0, a1, a3);
        check("rst_hold_stall1", a3, O_STALL);
        step(ld, 1'b1, a1, a3);
        check("rst_hold_during", a3, O_ZERO);
        step(z, 1'b0, a1, a3);
        check("rst_hold_after1", a3, O_ZERO);
        step(z, 1'b0, a1, a3);
        check("rst_hold_after2", a3, O_ZERO);

        // Random traffic on a small register range to force frequent matches.
        for (int i = 0; i < 3000; i++) begin
            s = fs($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 1) != 0) ? 1 : $urandom_range(0, 3),
                   $urandom_range(0, 1), ($urandom_range(0, 11) == 0) ? 1 : 0,
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
            r = ($urandom_range(0, 79) == 0);
            step(s, r, a1, a3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
